spi_byte_shifter: RTL and testbench

//  Serial front end of the SPI slave path. Deserialises the 1-bit MOSI line into WIDTH-bit

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_byte_shifter_if.sv | 29 ++
 rtl/spi_shift_reg.sv | 38 +++
 rtl/spi_byte_shifter.sv | 123 ++++++++++++
 tb/tb_spi_byte_shifter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: FSM states, default idle reply byte, command opcodes.
// No logic, no latency; consumed by the shifter and the byte-level controller.
// No flow control.
package spi_pkg;

  typedef enum logic {
    SPI_ST_IDLE   = 1'b0,
    SPI_ST_ACTIVE = 1'b1
  } spi_state_t;

  localparam logic [7:0] SPI_IDLE_BYTE_DEF = 8'h00;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam logic [7:0] SPI_CMD_STREAM = 8'h80;

endpackage

// File: rtl/spi_byte_shifter_if.sv
// Pin and byte-level bus between the SPI pads/controller and spi_byte_shifter.
// No logic, no latency.
// No backpressure: SPI master owns the clock; the controller must supply tx_byte on tx_load.
interface spi_byte_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] rx_byte;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_byte;
  logic             tx_load;
  logic             frame_start;
  logic             frame_abort;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output cs_n, mosi, tx_byte,
    input  miso, miso_oe, rx_byte, rx_valid, tx_load, frame_start, frame_abort, byte_count
  );

  modport slave (
    input  cs_n, mosi, tx_byte,
    output miso, miso_oe, rx_byte, rx_valid, tx_load, frame_start, frame_abort, byte_count
  );
endinterface

// File: rtl/spi_shift_reg.sv
// Load/shift register with serial in/out; direction set by SPI_SHIFTER_LSB_FIRST_EN.
// Latency: one sclk per load or shift; load wins over shift.
// No backpressure.
module spi_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
);

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_dat;
    end else if (shift_en) begin
`ifdef SPI_SHIFTER_LSB_FIRST_EN
      q <= {ser_in, q[WIDTH-1:1]};
`else
      q <= {q[WIDTH-2:0], ser_in};
`endif
    end
  end

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  assign ser_out = q[0];
`else
  assign ser_out = q[WIDTH-1];
`endif

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI slave serial front end: MOSI -> rx_byte, tx_byte -> MISO, frame/abort tracking (SPI_SHIFTER_LSB_FIRST_EN = LSB first).
// Latency: rx_byte on the edge sampling the last bit; reply goes out during the following byte.
// No backpressure: tx_byte must be valid whenever tx_load pulses.
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(SPI_IDLE_BYTE_DEF)
) (
  input  logic               sclk,
  input  logic               rst_n,
  spi_byte_shifter_if.slave  bus
);

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  spi_state_t       state;
  logic [BIT_W-1:0] bit_cnt;
  logic             cs_act;
  logic             byte_done;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_nxt;
  logic             rx_unused_ser;
  logic [WIDTH-1:0] tx_unused_q;

  assign cs_act    = ~bus.cs_n;
  assign byte_done = cs_act && (bit_cnt == LAST_BIT);

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  assign rx_nxt = {bus.mosi, rx_q[WIDTH-1:1]};
`else
  assign rx_nxt = {rx_q[WIDTH-2:0], bus.mosi};
`endif

  spi_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL ('0)
  ) u_rx_sr (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_dat ('0),
    .shift_en (cs_act),
    .ser_in   (bus.mosi),
    .q        (rx_q),
    .ser_out  (rx_unused_ser)
  );

  // Deselect reloads the idle byte so every frame opens with IDLE_BYTE on MISO.
  spi_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (IDLE_BYTE)
  ) u_tx_sr (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .load     (!cs_act || byte_done),
    .load_dat (cs_act ? bus.tx_byte : IDLE_BYTE),
    .shift_en (cs_act),
    .ser_in   (1'b0),
    .q        (tx_unused_q),
    .ser_out  (bus.miso)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state           <= SPI_ST_IDLE;
      bit_cnt         <= '0;
      bus.rx_byte     <= '0;
      bus.byte_count  <= '0;
      bus.rx_valid    <= 1'b0;
      bus.tx_load     <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_abort <= 1'b0;
      bus.miso_oe     <= 1'b0;
    end else begin
      bus.rx_valid    <= 1'b0;
      bus.tx_load     <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_abort <= 1'b0;

      case (state)
        SPI_ST_IDLE: begin
          if (cs_act) begin
            state           <= SPI_ST_ACTIVE;
            bus.miso_oe     <= 1'b1;
            bus.frame_start <= 1'b1;
            bus.byte_count  <= '0;
          end else begin
            bus.miso_oe <= 1'b0;
          end
        end
        SPI_ST_ACTIVE: begin
          if (!cs_act) begin
            state           <= SPI_ST_IDLE;
            bus.miso_oe     <= 1'b0;
            bus.frame_abort <= (bit_cnt != '0);
          end else begin
            bus.miso_oe <= 1'b1;
          end
        end
        default: state <= SPI_ST_IDLE;
      endcase

      // Bit/byte bookkeeping; the entering edge of a frame is already bit 0.
      if (!cs_act) begin
        bit_cnt <= '0;
      end else if (byte_done) begin
        bit_cnt      <= '0;
        bus.rx_byte  <= rx_nxt;
        bus.rx_valid <= 1'b1;
        bus.tx_load  <= 1'b1;
        if (bus.byte_count != '1) begin
          bus.byte_count <= bus.byte_count + 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: a CNT_W=8 and a CNT_W=2 instance share one stimulus stream.
module tb_spi_byte_shifter;
  import spi_pkg::*;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mb;
  logic       miso_smp;
  int         n_vld, n_fs, n_ab;

  spi_byte_shifter_if #(.WIDTH(8), .CNT_W(8)) bus ();
  spi_byte_shifter_if #(.WIDTH(8), .CNT_W(2)) bus_s ();

  assign bus_s.cs_n    = bus.cs_n;
  assign bus_s.mosi    = bus.mosi;
  assign bus_s.tx_byte = bus.tx_byte;

  spi_byte_shifter #(.WIDTH(8), .CNT_W(8), .IDLE_BYTE(8'h00)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  spi_byte_shifter #(.WIDTH(8), .CNT_W(2), .IDLE_BYTE(8'h00)) dut_s (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mb    = 8'h00;
    n_vld = 0;
    n_fs  = 0;
    n_ab  = 0;
  endtask

  // One sclk edge: drive on negedge, sample MISO before the posedge, observe 1 time unit after.
  task automatic edge_go(input logic cs, input logic b);
    @(negedge sclk);
    bus.cs_n = cs;
    bus.mosi = b;
    #1 miso_smp = bus.miso;
    @(posedge sclk);
    #1;
    if (bus.rx_valid === 1'b1)    n_vld++;
    if (bus.frame_start === 1'b1) n_fs++;
    if (bus.frame_abort === 1'b1) n_ab++;
  endtask

  task automatic send_bits(input logic [7:0] d, input int nb);
    for (int i = 0; i < nb; i++) begin
`ifdef SPI_SHIFTER_LSB_FIRST_EN
      edge_go(1'b0, d[i]);
      mb = {miso_smp, mb[7:1]};
`else
      edge_go(1'b0, d[7-i]);
      mb = {mb[6:0], miso_smp};
`endif
    end
  endtask

  initial begin
    bus.cs_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_byte = 8'h00;
    rst_n       = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    chk("rst_miso_oe",    32'(bus.miso_oe),     32'h0);
    chk("rst_rx_valid",   32'(bus.rx_valid),    32'h0);
    chk("rst_rx_byte",    32'(bus.rx_byte),     32'h00);
    chk("rst_byte_count", 32'(bus.byte_count),  32'h0);
    chk("rst_frame_start",32'(bus.frame_start), 32'h0);
    chk("rst_miso",       32'(bus.miso),        32'h0);
    @(negedge sclk);
    rst_n = 1'b1;

    // Byte 0 of a frame: MISO carries IDLE_BYTE, reply A5 captured at the 8th edge.
    bus.tx_byte = 8'hA5;
    clr();
    send_bits(8'h03, 8);
    chk("b0_frame_start_cnt", 32'(n_fs),           32'd1);
    chk("b0_rx_valid_cnt",    32'(n_vld),          32'd1);
    chk("b0_rx_valid_8th",    32'(bus.rx_valid),   32'h1);
    chk("b0_tx_load",         32'(bus.tx_load),    32'h1);
    chk("b0_rx_byte",         32'(bus.rx_byte),    32'h03);
    chk("b0_miso_byte",       32'(mb),             32'h00);
    chk("b0_byte_count",      32'(bus.byte_count), 32'd1);
    chk("b0_miso_oe",         32'(bus.miso_oe),    32'h1);

    bus.tx_byte = 8'h3C;
    clr();
    send_bits(8'hC3, 8);
    chk("b1_miso_byte",   32'(mb),             32'hA5);
    chk("b1_rx_byte",     32'(bus.rx_byte),    32'hC3);
    chk("b1_byte_count",  32'(bus.byte_count), 32'd2);
    chk("b1_no_fstart",   32'(n_fs),           32'd0);

    // Abort after 3 bits of a third byte.
    clr();
    send_bits(8'h5A, 3);
    edge_go(1'b1, 1'b0);
    chk("ab_frame_abort", 32'(bus.frame_abort), 32'h1);
    chk("ab_no_rx_valid", 32'(n_vld),           32'd0);
    chk("ab_rx_byte_kept",32'(bus.rx_byte),     32'hC3);
    chk("ab_miso_oe",     32'(bus.miso_oe),     32'h0);
    chk("ab_count_kept",  32'(bus.byte_count),  32'd2);
    edge_go(1'b1, 1'b0);
    chk("ab_pulse_1cyc",  32'(bus.frame_abort), 32'h0);

    // Back-to-back frames with a single deselected edge between them.
    bus.tx_byte = 8'h77;
    clr();
    send_bits(8'h5A, 8);
    edge_go(1'b1, 1'b0);
    chk("bb_a_fstart",    32'(n_fs),           32'd1);
    chk("bb_a_no_abort",  32'(n_ab),           32'd0);
    chk("bb_a_rx_byte",   32'(bus.rx_byte),    32'h5A);
    clr();
    send_bits(8'h96, 8);
    chk("bb_b_fstart",    32'(n_fs),           32'd1);
    chk("bb_b_miso_idle", 32'(mb),             32'h00);
    chk("bb_b_count",     32'(bus.byte_count), 32'd1);
    chk("bb_b_rx_byte",   32'(bus.rx_byte),    32'h96);
    edge_go(1'b1, 1'b0);

    // Reset at bit 5 of a byte while still selected.
    clr();
    send_bits(8'hFF, 5);
    @(negedge sclk);
    rst_n    = 1'b0;
    bus.cs_n = 1'b0;
    @(posedge sclk);
    #1;
    chk("mr_rx_byte",   32'(bus.rx_byte),     32'h00);
    chk("mr_count",     32'(bus.byte_count),  32'd0);
    chk("mr_count_s",   32'(bus_s.byte_count),32'd0);
    chk("mr_miso_oe",   32'(bus.miso_oe),     32'h0);
    chk("mr_abort",     32'(bus.frame_abort), 32'h0);
    chk("mr_rx_valid",  32'(bus.rx_valid),    32'h0);
    chk("mr_miso",      32'(bus.miso),        32'h0);
    @(negedge sclk);
    rst_n    = 1'b1;
    bus.cs_n = 1'b1;
    @(posedge sclk);
    #1;
    chk("mr_rel_abort", 32'(bus.frame_abort), 32'h0);
    chk("mr_rel_oe",    32'(bus.miso_oe),     32'h0);

    // Five bytes in one frame: CNT_W=2 instance saturates at 3.
    clr();
    for (int k = 0; k < 5; k++) begin
      bus.tx_byte = 8'(k);
      send_bits(8'(8'h10 + k), 8);
      chk("sat_count_w8", 32'(bus.byte_count),   32'(k + 1));
      chk("sat_count_w2", 32'(bus_s.byte_count), 32'((k < 3) ? k + 1 : 3));
    end
    chk("sat_rx_valid_cnt", 32'(n_vld),          32'd5);
    chk("sat_rx_byte_s",    32'(bus_s.rx_byte),  32'h14);
    edge_go(1'b1, 1'b0);

`ifdef SPI_SHIFTER_LSB_FIRST_EN
    // LSB-first: bits 1,1,0,0,0,0,0,0 assemble 8'h03; reply 8'h01 leads with a 1.
    bus.tx_byte = 8'h01;
    clr();
    send_bits(8'h03, 8);
    chk("lsb_rx_byte", 32'(bus.rx_byte), 32'h03);
    bus.tx_byte = 8'h00;
    send_bits(8'h00, 1);
    chk("lsb_first_miso", 32'(miso_smp), 32'h1);
    edge_go(1'b1, 1'b0);
    chk("lsb_abort", 32'(bus.frame_abort), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
